core_lsu: RTL and testbench
===========================

# core_lsu

Parametrised multicycle load/store unit between the core's execute stage and the data-memory port. It accepts one load or store per request handshake and checks alignment. It generates byte enables and lane-shifted store data, waits a variable number of cycles for memory acknowledge with a timeout, and returns sign/zero-extended load data with an error code. It replaces the fixed single-cycle, always-ready data-memory access of the current core.

## Interface
- XLEN, 32: data width; 32 or 64. Byte lanes L = XLEN/8, offset width O = log2(L).
- ADDR_W, 32: address width.
- MAX_WAIT, 255: maximum cycles MEM_REQ is held without MEM_ACK before timeout; ≥1.

- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when XLEN=64).
- REQ_UNSIGNED  in  1  zero-extend the load result (LBU/LHU/LWU).
- REQ_ADDR  in  ADDR_W  byte address.
- REQ_WDATA  in  XLEN  store data, right-aligned.
- REQ_RD  in  5  destination register tag, returned unchanged.
- RESP_VALID  out  1  one-cycle response pulse.
- RESP_RDATA  out  XLEN  extended load data; 0 for stores and errors.
- RESP_RD  out  5  tag of the completed request.
- RESP_ERR  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- MEM_REQ  out  1  memory access request.
- MEM_WE  out  1  write strobe, qualified by MEM_REQ.
- MEM_ADDR  out  ADDR_W  REQ_ADDR with low O bits cleared.
- MEM_BE  out  L  active byte lanes (loads and stores).
- MEM_WDATA  out  XLEN  store data shifted to lanes.
- MEM_ACK  in  1  memory completed the access this cycle.
- MEM_RDATA  in  XLEN  read data, valid when MEM_ACK=1.

## Operation
- FSM states are IDLE, ACCESS and RESP. All outputs are registered.
- IDLE:
  - REQ_READY=1.
  - Acceptance requires REQ_VALID=1 and REQ_READY=1 at an edge; the unit then latches WE, SIZE, UNSIGNED, ADDR, WDATA and RD.
  - If the size is illegal (3 with XLEN=32) → RESP, ERR=11.
  - Else if misaligned (ADDR mod 2^SIZE ≠ 0) → RESP, ERR=01. No memory access occurs in either case.
  - Else → ACCESS, with MEM_REQ=1, MEM_ADDR, MEM_BE, MEM_WE and MEM_WDATA driven, wait counter cleared.
- Lane rules (off = ADDR[O-1:0]):
  - MEM_BE = ((1<<2^SIZE)-1) << off.
  - MEM_WDATA = REQ_WDATA << (8·off); unused lanes are 0.
- ACCESS:
  - REQ_READY=0. MEM_* outputs are held stable until the exit edge.
  - MEM_ACK=1 at an edge → RESP, ERR=00, MEM_REQ=0. For loads, the unit captures MEM_RDATA >> (8·off), truncates it to 2^SIZE bytes, then sign-extends (UNSIGNED=0) or zero-extends (UNSIGNED=1) to XLEN.
  - Else the counter increments. When the counter reaches MAX_WAIT-1 with no ACK → RESP, ERR=10, MEM_REQ=0.
  - ACK on the last allowed cycle wins over timeout.
  - MEM_ACK in IDLE or RESP is ignored.
- RESP:
  - RESP_VALID=1 for exactly one cycle; there is no backpressure.
  - RESP_RD = latched tag.
  - Next state is IDLE.
- REQ_READY is not asserted during RESP, so there is at most one outstanding request.
- Reset (any state, including mid-ACCESS):
  - State IDLE; counter 0; outputs as in Timing.
  - An access in flight is abandoned with no response.
  - A MEM_ACK arriving after reset release is ignored.

## Timing
- Reset values: REQ_READY 0, RESP_VALID 0, RESP_RDATA 0, RESP_RD 0, RESP_ERR 00, MEM_REQ 0, MEM_WE 0, MEM_ADDR 0, MEM_BE 0, MEM_WDATA 0.
- REQ_READY rises at the first edge after RST_N deasserts.
- Request accepted at edge N:
  - MEM_REQ is high from cycle N+1.
  - ACK sampled at edge N+1+k (k wait cycles) → RESP_VALID high in cycle N+2+k.
  - Zero-wait latency is therefore 2 cycles.
- Error paths (misaligned, illegal size): RESP_VALID in cycle N+1; MEM_REQ never asserts.
- Timeout: MEM_REQ is high for exactly MAX_WAIT cycles; RESP_VALID follows in the next cycle.
- REQ_READY returns to 1 the cycle after RESP_VALID. Minimum request spacing is 3 cycles (zero-wait) or 2 cycles (error).

## Test plan
- XLEN=32, LW addr 0x100, ACK in the first MEM_REQ cycle with RDATA 0xDEADBEEF → MEM_ADDR 0x100, BE 1111, RESP_VALID at N+2, RDATA 0xDEADBEEF, ERR 00, RD echoed.
- LB addr 0x103 with MEM_RDATA 0x80112233 → BE 1000, RDATA 0xFFFFFF80. Repeated as LBU → 0x00000080. LH addr 0x102 → 0xFFFF8011.
- SH addr 0x102, WDATA 0x0000ABCD, ACK after 3 wait cycles → MEM_ADDR 0x100, WDATA 0xABCD0000, BE 1100, MEM_WE 1 for 4 cycles, RESP RDATA 0.
- LW addr 0x102 → no MEM_REQ, RESP_VALID at N+1, ERR 01. SIZE=3 with XLEN=32 → ERR 11.
- MAX_WAIT=4, ACK never → MEM_REQ high exactly 4 cycles, ERR 10. With ACK in the 4th cycle instead → ERR 00 with data.
- RST_N pulsed low during ACCESS → MEM_REQ 0 immediately, no RESP_VALID, subsequent ACK ignored. XLEN=64 LD addr 0x8 and LWU addr 0xC → BE 0xFF/0xF0 with correct extension.

Source files
------------

// File: rtl/core_lsu.sv
`timescale 1ns/1ps
// core_lsu: multicycle load/store unit between execute and the data-memory port.
// Checks alignment, steers byte lanes, waits for MEM_ACK with a timeout, extends load data.
module core_lsu #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_UNSIGNED,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [XLEN-1:0]   REQ_WDATA,
    input  logic [4:0]        REQ_RD,
    output logic              RESP_VALID,
    output logic [XLEN-1:0]   RESP_RDATA,
    output logic [4:0]        RESP_RD,
    output logic [1:0]        RESP_ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [XLEN/8-1:0] MEM_BE,
    output logic [XLEN-1:0]   MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [XLEN-1:0]   MEM_RDATA
);
    localparam int L        = XLEN / 8;
    localparam int O        = $clog2(L);
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam bit DWORD_OK = (XLEN == 64);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [O-1:0]       off_q, off_d;
    logic [4:0]         rd_q, rd_d;

    logic               ready_q, ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_rdata_q, resp_rdata_d;
    logic [4:0]         resp_rd_q, resp_rd_d;
    logic [1:0]         resp_err_q, resp_err_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [L-1:0]       mem_be_q, mem_be_d;
    logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;

    // Request-side lane steering, evaluated on the incoming request.
    logic [O-1:0]       req_off;
    logic [O-1:0]       align_mask;
    logic [L-1:0]       size_mask;
    logic [L-1:0]       req_be;
    logic [XLEN-1:0]    wdata_trunc;
    logic [XLEN-1:0]    req_wdata_lanes;
    logic               size_illegal;
    logic               misaligned;

    assign req_off = REQ_ADDR[O-1:0];

    always_comb begin
        // NOTE: every variable written here is given a default first, so no latch is inferred.
        size_mask   = '0;
        align_mask  = '0;
        wdata_trunc = '0;
        for (int i = 0; i < L; i++) begin
            size_mask[i] = (i < (1 << REQ_SIZE));
        end
        for (int i = 0; i < O; i++) begin
            align_mask[i] = (i < int'(REQ_SIZE));
        end
        for (int i = 0; i < L; i++) begin
            wdata_trunc[8*i +: 8] = REQ_WDATA[8*i +: 8] & {8{size_mask[i]}};
        end
        req_be          = size_mask << req_off;
        req_wdata_lanes = wdata_trunc << {req_off, 3'b000};
        size_illegal    = (REQ_SIZE == 2'd3) && !DWORD_OK;
        misaligned      = |(req_off & align_mask);
    end

    // Load path: right-align the addressed lanes, then sign- or zero-extend above the access size.
    logic [XLEN-1:0]    load_shifted;
    logic [XLEN-1:0]    load_data;
    logic               load_sign;

    always_comb begin
        load_shifted = MEM_RDATA >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_sign = load_shifted[7];
            2'd1:    load_sign = load_shifted[15];
            2'd2:    load_sign = load_shifted[31];
            default: load_sign = load_shifted[XLEN-1];
        endcase
        load_sign = load_sign & ~uns_q;
        load_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            load_data[i] = (i < (8 << size_q)) ? load_shifted[i] : load_sign;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        rd_d         = rd_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (REQ_VALID && ready_q) begin
                    ready_d = 1'b0;
                    size_d  = REQ_SIZE;
                    uns_d   = REQ_UNSIGNED;
                    off_d   = req_off;
                    rd_d    = REQ_RD;
                    if (size_illegal || misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = size_illegal ? ERR_SIZE : ERR_ALIGN;
                        resp_rdata_d = '0;
                        resp_rd_d    = REQ_RD;
                    end else begin
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = REQ_WE;
                        mem_addr_d  = {REQ_ADDR[ADDR_W-1:O], {O{1'b0}}};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata_lanes;
                    end
                end
            end

            S_ACCESS: begin
                // An ACK on the final allowed cycle takes priority over the timeout.
                if (MEM_ACK) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = mem_we_q ? '0 : load_data;
                    resp_rd_d    = rd_q;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TOUT;
                    resp_rdata_d = '0;
                    resp_rd_d    = rd_q;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= ERR_OK;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign REQ_READY  = ready_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_RDATA = resp_rdata_q;
    assign RESP_RD    = resp_rd_q;
    assign RESP_ERR   = resp_err_q;
    assign MEM_REQ    = mem_req_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_BE     = mem_be_q;
    assign MEM_WDATA  = mem_wdata_q;

endmodule

// File: tb/tb_core_lsu.sv
`timescale 1ns/1ps
// tb_core_lsu: directed vectors against a 32-bit and a 64-bit core_lsu, both with MAX_WAIT=4.
// Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
module tb_core_lsu;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel64;
    logic        req_valid, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        d32_ready, d32_resp_valid, d32_mem_req, d32_mem_we;
    logic [31:0] d32_resp_rdata, d32_mem_addr, d32_mem_wdata;
    logic [4:0]  d32_resp_rd;
    logic [1:0]  d32_resp_err;
    logic [3:0]  d32_mem_be;

    logic        d64_ready, d64_resp_valid, d64_mem_req, d64_mem_we;
    logic [63:0] d64_resp_rdata, d64_mem_wdata;
    logic [31:0] d64_mem_addr;
    logic [4:0]  d64_resp_rd;
    logic [1:0]  d64_resp_err;
    logic [7:0]  d64_mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut32 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid & ~sel64), .REQ_READY(d32_ready), .REQ_WE(req_we),
        .REQ_SIZE(req_size), .REQ_UNSIGNED(req_uns), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata[31:0]), .REQ_RD(req_rd),
        .RESP_VALID(d32_resp_valid), .RESP_RDATA(d32_resp_rdata), .RESP_RD(d32_resp_rd),
        .RESP_ERR(d32_resp_err), .MEM_REQ(d32_mem_req), .MEM_WE(d32_mem_we),
        .MEM_ADDR(d32_mem_addr), .MEM_BE(d32_mem_be), .MEM_WDATA(d32_mem_wdata),
        .MEM_ACK(mem_ack & ~sel64), .MEM_RDATA(mem_rdata[31:0])
    );

    core_lsu #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut64 (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid & sel64), .REQ_READY(d64_ready), .REQ_WE(req_we),
        .REQ_SIZE(req_size), .REQ_UNSIGNED(req_uns), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .REQ_RD(req_rd),
        .RESP_VALID(d64_resp_valid), .RESP_RDATA(d64_resp_rdata), .RESP_RD(d64_resp_rd),
        .RESP_ERR(d64_resp_err), .MEM_REQ(d64_mem_req), .MEM_WE(d64_mem_we),
        .MEM_ADDR(d64_mem_addr), .MEM_BE(d64_mem_be), .MEM_WDATA(d64_mem_wdata),
        .MEM_ACK(mem_ack & sel64), .MEM_RDATA(mem_rdata)
    );

    // View of whichever instance is selected, widened to 64 bits.
    logic        o_ready, o_resp_valid, o_mem_req, o_mem_we;
    logic [63:0] o_resp_rdata, o_mem_wdata;
    logic [31:0] o_mem_addr;
    logic [4:0]  o_resp_rd;
    logic [1:0]  o_resp_err;
    logic [7:0]  o_mem_be;

    assign o_ready      = sel64 ? d64_ready      : d32_ready;
    assign o_resp_valid = sel64 ? d64_resp_valid : d32_resp_valid;
    assign o_resp_rdata = sel64 ? d64_resp_rdata : {32'h0, d32_resp_rdata};
    assign o_resp_rd    = sel64 ? d64_resp_rd    : d32_resp_rd;
    assign o_resp_err   = sel64 ? d64_resp_err   : d32_resp_err;
    assign o_mem_req    = sel64 ? d64_mem_req    : d32_mem_req;
    assign o_mem_we     = sel64 ? d64_mem_we     : d32_mem_we;
    assign o_mem_addr   = sel64 ? d64_mem_addr   : d32_mem_addr;
    assign o_mem_be     = sel64 ? d64_mem_be     : {4'h0, d32_mem_be};
    assign o_mem_wdata  = sel64 ? d64_mem_wdata  : {32'h0, d32_mem_wdata};

    typedef struct {
        bit          sel64;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        int          ack_wait;   // wait cycles before ACK; -1 = never
        logic [63:0] mem_rdata;
        logic [31:0] exp_addr;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [1:0]  exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;    // cycles from acceptance edge to RESP_VALID
        int          exp_req;    // cycles MEM_REQ is high
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(
        input bit s64, input bit we, input logic [1:0] size, input bit uns,
        input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
        input int ack_wait, input logic [63:0] mrd,
        input logic [31:0] e_addr, input logic [7:0] e_be, input logic [63:0] e_wdata,
        input logic [1:0] e_err, input logic [63:0] e_rdata, input int e_lat, input int e_req);
        vec_t v;
        v.sel64 = s64;  v.we = we;  v.size = size;  v.uns = uns;
        v.addr = addr;  v.wdata = wdata;  v.rd = rd;
        v.ack_wait = ack_wait;  v.mem_rdata = mrd;
        v.exp_addr = e_addr;  v.exp_be = e_be;  v.exp_wdata = e_wdata;
        v.exp_err = e_err;  v.exp_rdata = e_rdata;  v.exp_lat = e_lat;  v.exp_req = e_req;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int lat;
        int req_cyc;
        int we_cyc;
        int t;
        sel64 = v.sel64;
        #0;
        t = 0;
        while (!o_ready && t < 20) begin
            tick();
            t++;
        end
        check($sformatf("v%0d ready", idx), 64'(o_ready), 64'd1);
        if (!o_ready) return;

        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_uns   = v.uns;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        tick();
        req_valid = 1'b0;

        lat = 0;
        req_cyc = 0;
        we_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            mem_ack   = (v.ack_wait >= 0) && (c == v.ack_wait + 1);
            mem_rdata = v.mem_rdata;
            if (o_resp_valid) begin
                lat = c;
                break;
            end
            if (o_mem_req) begin
                req_cyc++;
                if (o_mem_we) we_cyc++;
                check($sformatf("v%0d mem_addr c%0d", idx, c), 64'(o_mem_addr), 64'(v.exp_addr));
                check($sformatf("v%0d mem_be c%0d", idx, c), 64'(o_mem_be), 64'(v.exp_be));
                if (v.we)
                    check($sformatf("v%0d mem_wdata c%0d", idx, c), o_mem_wdata, v.exp_wdata);
            end
            tick();
        end
        mem_ack = 1'b0;

        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("v%0d mem_req cycles", idx), 64'(req_cyc), 64'(v.exp_req));
        check($sformatf("v%0d mem_we cycles", idx), 64'(we_cyc), v.we ? 64'(v.exp_req) : 64'd0);
        check($sformatf("v%0d resp_err", idx), 64'(o_resp_err), 64'(v.exp_err));
        check($sformatf("v%0d resp_rdata", idx), o_resp_rdata, v.exp_rdata);
        check($sformatf("v%0d resp_rd", idx), 64'(o_resp_rd), 64'(v.rd));
        check($sformatf("v%0d mem_req at resp", idx), 64'(o_mem_req), 64'd0);
        tick();
        check($sformatf("v%0d resp pulse end", idx), 64'(o_resp_valid), 64'd0);
        check($sformatf("v%0d ready after resp", idx), 64'(o_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #0;
            check($sformatf("%s d%0d ready", tag, s), 64'(o_ready), 64'd0);
            check($sformatf("%s d%0d resp_valid", tag, s), 64'(o_resp_valid), 64'd0);
            check($sformatf("%s d%0d resp_rdata", tag, s), o_resp_rdata, 64'd0);
            check($sformatf("%s d%0d resp_rd", tag, s), 64'(o_resp_rd), 64'd0);
            check($sformatf("%s d%0d resp_err", tag, s), 64'(o_resp_err), 64'd0);
            check($sformatf("%s d%0d mem_req", tag, s), 64'(o_mem_req), 64'd0);
            check($sformatf("%s d%0d mem_we", tag, s), 64'(o_mem_we), 64'd0);
            check($sformatf("%s d%0d mem_addr", tag, s), 64'(o_mem_addr), 64'd0);
            check($sformatf("%s d%0d mem_be", tag, s), 64'(o_mem_be), 64'd0);
            check($sformatf("%s d%0d mem_wdata", tag, s), o_mem_wdata, 64'd0);
        end
        sel64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        int rq_seen;

        //         s64 we sz uns addr          wdata                  rd  ack mem_rdata               e_addr        e_be   e_wdata                e_err  e_rdata                lat req
        vecs[0]  = mk(0, 0, 2, 0, 32'h100, 64'h0,                 1,  0, 64'hDEADBEEF,          32'h100, 8'h0F, 64'h0,                2'b00, 64'h00000000DEADBEEF, 2, 1);
        vecs[1]  = mk(0, 0, 0, 0, 32'h103, 64'h0,                 2,  0, 64'h80112233,          32'h100, 8'h08, 64'h0,                2'b00, 64'h00000000FFFFFF80, 2, 1);
        vecs[2]  = mk(0, 0, 0, 1, 32'h103, 64'h0,                 3,  0, 64'h80112233,          32'h100, 8'h08, 64'h0,                2'b00, 64'h0000000000000080, 2, 1);
        vecs[3]  = mk(0, 0, 1, 0, 32'h102, 64'h0,                 4,  0, 64'h80112233,          32'h100, 8'h0C, 64'h0,                2'b00, 64'h00000000FFFF8011, 2, 1);
        vecs[4]  = mk(0, 1, 1, 0, 32'h102, 64'h0000ABCD,          5,  3, 64'h12345678,          32'h100, 8'h0C, 64'hABCD0000,         2'b00, 64'h0,                5, 4);
        vecs[5]  = mk(0, 0, 2, 0, 32'h102, 64'h0,                 6,  0, 64'h11111111,          32'h0,   8'h00, 64'h0,                2'b01, 64'h0,                1, 0);
        vecs[6]  = mk(0, 0, 3, 0, 32'h100, 64'h0,                 7,  0, 64'h11111111,          32'h0,   8'h00, 64'h0,                2'b11, 64'h0,                1, 0);
        vecs[7]  = mk(0, 0, 2, 0, 32'h104, 64'h0,                 8, -1, 64'h55555555,          32'h104, 8'h0F, 64'h0,                2'b10, 64'h0,                5, 4);
        vecs[8]  = mk(0, 0, 2, 0, 32'h108, 64'h0,                 9,  3, 64'hCAFEF00D,          32'h108, 8'h0F, 64'h0,                2'b00, 64'h00000000CAFEF00D, 5, 4);
        vecs[9]  = mk(0, 1, 0, 0, 32'h101, 64'hFFFFFF5A,         10,  1, 64'h0,                 32'h100, 8'h02, 64'h00005A00,         2'b00, 64'h0,                3, 2);
        vecs[10] = mk(0, 0, 1, 0, 32'h100, 64'h0,                11,  0, 64'h1234F00F,          32'h100, 8'h03, 64'h0,                2'b00, 64'h00000000FFFFF00F, 2, 1);
        vecs[11] = mk(0, 0, 1, 1, 32'h100, 64'h0,                12,  0, 64'h1234F00F,          32'h100, 8'h03, 64'h0,                2'b00, 64'h000000000000F00F, 2, 1);
        vecs[12] = mk(0, 1, 1, 0, 32'h101, 64'h0,                13,  0, 64'h0,                 32'h0,   8'h00, 64'h0,                2'b01, 64'h0,                1, 0);
        vecs[13] = mk(1, 0, 3, 0, 32'h8,   64'h0,                14,  0, 64'h8877665544332211, 32'h8,   8'hFF, 64'h0,                2'b00, 64'h8877665544332211, 2, 1);
        vecs[14] = mk(1, 0, 2, 1, 32'hC,   64'h0,                15,  0, 64'h8000000100000000, 32'h8,   8'hF0, 64'h0,                2'b00, 64'h0000000080000001, 2, 1);
        vecs[15] = mk(1, 0, 2, 0, 32'hC,   64'h0,                16,  0, 64'h8000000100000000, 32'h8,   8'hF0, 64'h0,                2'b00, 64'hFFFFFFFF80000001, 2, 1);
        vecs[16] = mk(1, 1, 3, 0, 32'h10,  64'h0123456789ABCDEF, 17,  2, 64'h0,                 32'h10,  8'hFF, 64'h0123456789ABCDEF, 2'b00, 64'h0,                4, 3);
        vecs[17] = mk(1, 0, 3, 0, 32'h4,   64'h0,                18,  0, 64'h0,                 32'h0,   8'h00, 64'h0,                2'b01, 64'h0,                1, 0);
        vecs[18] = mk(1, 0, 3, 0, 32'h18,  64'h0,                19, -1, 64'h0,                 32'h18,  8'hFF, 64'h0,                2'b10, 64'h0,                5, 4);
        vecs[19] = mk(1, 1, 0, 0, 32'h1F,  64'h00000000000000AB, 20,  0, 64'h0,                 32'h18,  8'h80, 64'hAB00000000000000, 2'b00, 64'h0,                2, 1);

        rst_n = 1'b0;
        sel64 = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        #1;
        check_reset_values("reset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready before first edge", 64'(o_ready), 64'd0);
        tick();
        check("ready after first edge d32", 64'(d32_ready), 64'd1);
        check("ready after first edge d64", 64'(d64_ready), 64'd1);

        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset pulsed mid-ACCESS: access abandoned, no response, later ACK ignored.
        sel64 = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0;
        req_addr = 32'h200; req_rd = 5'd21;
        tick();
        req_valid = 1'b0;
        check("rst mid access mem_req", 64'(o_mem_req), 64'd1);
        tick();
        check("rst still waiting mem_req", 64'(o_mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid-access reset");
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 64'h0BADF00D;
        rv_seen = 0;
        rq_seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) check("ready after reset release", 64'(o_ready), 64'd1);
            if (o_resp_valid) rv_seen++;
            if (o_mem_req) rq_seen++;
        end
        mem_ack = 1'b0;
        check("no resp after reset", 64'(rv_seen), 64'd0);
        check("no mem_req after reset", 64'(rq_seen), 64'd0);
        run_txn(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
